rom_burst_reader: RTL and testbench
===================================

Name: rom_burst_reader

Overview:
Parametrised synchronous ROM with a burst-read engine. It generalises the team's 16x8 squares ROM to ADDR_W/DATA_W, and holds rom[i] = (i*i) mod 2^DATA_W. A single start pulse streams LEN consecutive words with address wrap-around and a valid/done handshake. It sits between control FSMs and datapath blocks that need table lookups or sequential table sweeps.

Parameters:
ADDR_W, 4, address width; depth = 2^ADDR_W words
DATA_W, 8, word width; table entry i = (i*i) truncated to DATA_W bits

Ports:
clk  in  1  single clock, all state updates on rising edge
rst_n  in  1  reset, asynchronous, active-low
cs  in  1  chip select; must be high for a start to be accepted and for a burst to continue
rd  in  1  start strobe, sampled on rising clk
addr  in  ADDR_W  start address, sampled with rd
len  in  ADDR_W+1  burst length in words, 1..2^ADDR_W, sampled with rd
data_out  out  DATA_W  registered read data
data_valid  out  1  data_out carries a new beat this cycle
done  out  1  one-cycle pulse on the final beat of a completed burst
busy  out  1  burst in progress (state == BURST)

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, data_out=0, data_valid=0, done=0, busy=0, ptr=0, cnt=0. Table contents are not affected by reset.
- FSM states are IDLE and BURST.
- IDLE, transition to BURST:
  - Condition at edge k: cs=1, rd=1 and len!=0.
  - Action: ptr<=addr, cnt<=len, busy=1 after edge k.
- IDLE, inputs ignored:
  - len=0 with rd=1: no-op, stays IDLE, no done.
  - cs=0: rd ignored.
- BURST, each edge while cs=1:
  - data_out<=rom[ptr], data_valid<=1.
  - ptr<=ptr+1, wrapping modulo 2^ADDR_W (15 -> 0 for ADDR_W=4).
  - cnt<=cnt-1.
- BURST, final beat (cnt==1 at the edge):
  - done<=1 in the same cycle as the last data_valid.
  - State returns to IDLE.
- Timing:
  - Latency: beat i is valid after edge k+1+i; the last beat is valid after edge k+len.
  - busy is high in the cycles after edges k..k+len-1.
  - A new start can be accepted no earlier than edge k+len+1 (one idle cycle between bursts).
- rd asserted while BURST: ignored. addr and len are not resampled.
- cs=0 during BURST (abort):
  - At that edge: state->IDLE, data_valid<=0, done stays 0, busy drops.
  - data_out holds its last value.
  - Partial beats already delivered stand.
- IDLE, or any cycle without a beat: data_valid=0, done=0, data_out holds its last value. It never goes to X; this is a change from the previous generation.
- Width rules:
  - len is ADDR_W+1 bits so that a full-depth burst (2^ADDR_W) is expressible.
  - len > 2^ADDR_W is clamped to 2^ADDR_W.
- Reset mid-burst: immediate return to the reset values above. No done pulse.

Decomposition:
- Package rom_burst_pkg:
  - State encoding: IDLE=1'b0, BURST=1'b1.
  - Constant function sq_entry(i, DATA_W) used for table initialisation.
  - Localparam DEPTH = 2^ADDR_W.
- Sub-module rom_core:
  - Parametrised storage array initialised from sq_entry.
  - Combinational index by ptr; data_out is registered in the parent.
- The parent holds the FSM, ptr, cnt and the output registers.

Test Plan (ADDR_W=4, DATA_W=8):
1. Reset: rst_n=0 asserted asynchronously between edges -> data_out=0x00, data_valid=0, done=0, busy=0 immediately. Release; with no rd, outputs stay at 0.
2. Single read: cs=1, rd=1, addr=5, len=1 at edge k -> after k+1: data_out=0x19, data_valid=1, done=1. After k+2: data_valid=0, data_out stays 0x19.
3. Wrapping burst: addr=13, len=5 -> beats 0xA9, 0xC4, 0xE1, 0x00, 0x01 on consecutive cycles. done only with 0x01. busy high for 5 cycles.
4. Full depth and zero length:
   - len=16, addr=0 -> 16 beats 0x00, 0x01, 0x04 ... 0xC4, 0xE1, then done.
   - len=0 -> no beats, busy stays 0.
5. Abort: burst addr=2, len=6; drop cs after 2 beats (0x04, 0x09) -> data_valid=0 at the next edge, done never pulses, data_out holds 0x09, busy=0.
6. Interference and mid-burst reset:
   - rd=1 with addr=0 during a burst from addr=8 -> sequence 0x40, 0x51, ... unaffected.
   - rst_n low mid-burst -> outputs return to reset values at once. A later start works normally.

Source files
------------

// File: rtl/rom_burst_pkg.sv
// rom_burst_pkg: shared types and helpers for the squares ROM burst reader.
// Holds FSM encoding, default geometry and the table entry function.
package rom_burst_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;
    localparam int DEPTH      = 2 ** ADDR_W_DEF;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    function automatic logic [63:0] sq_entry(
        input int unsigned i,
        input int unsigned dw
    );
        logic [63:0] sq;
        sq = 64'(i) * 64'(i);
        if (dw < 64) begin
            sq = sq & ((64'd1 << dw) - 64'd1);
        end
        return sq;
    endfunction

endpackage

// File: rtl/rom_core.sv
// rom_core: constant squares table, entry i = (i*i) truncated to DATA_W.
// Read is combinational; the parent registers the word.
module rom_core #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic [ADDR_W-1:0] ptr,
    output logic [DATA_W-1:0] rdata
);
    import rom_burst_pkg::*;

    localparam int NWORDS = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [NWORDS];

    for (genvar g = 0; g < NWORDS; g++) begin : g_tab
        assign mem[g] = DATA_W'(sq_entry(g, DATA_W));
    end

    assign rdata = mem[ptr];

endmodule

// File: rtl/rom_burst_reader.sv
// rom_burst_reader: squares ROM with a start-pulse burst engine.
// Streams len words from addr with wrap-around, valid/done handshake.
module rom_burst_reader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs,
    input  logic              rd,
    input  logic [ADDR_W-1:0] addr,
    input  logic [ADDR_W:0]   len,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              done,
    output logic              busy
);
    import rom_burst_pkg::*;

    localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W:0]   cnt_q;
    logic [ADDR_W:0]   len_eff;
    logic [DATA_W-1:0] rom_word;
    logic              start;
    logic              beat;
    logic              last;

    rom_core #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_rom (
        .ptr   (ptr_q),
        .rdata (rom_word)
    );

    assign len_eff = (len > LEN_MAX) ? LEN_MAX : len;
    assign busy    = (state_q == BURST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus start/beat/last strobes for the datapath.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        beat    = 1'b0;
        last    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cs && rd && (len != '0)) begin
                    start   = 1'b1;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (!cs) begin
                    state_d = IDLE;
                end else begin
                    beat = 1'b1;
                    if (cnt_q == CNT_ONE) begin
                        last    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pointer, counter and registered outputs; data_out holds between beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            cnt_q      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            data_valid <= beat;
            done       <= last;
            if (start) begin
                ptr_q <= addr;
                cnt_q <= len_eff;
            end
            if (beat) begin
                data_out <= rom_word;
                ptr_q    <= ptr_q + ADDR_W'(1);
                cnt_q    <= cnt_q - CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_rom_burst_reader.sv
// tb_rom_burst_reader: scoreboard bench for the squares ROM burst reader.
// Expected beats are queued at start and popped as data_valid beats arrive.
module tb_rom_burst_reader;

    logic       clk;
    logic       rst_n;
    logic       cs;
    logic       rd;
    logic [3:0] addr;
    logic [4:0] len;
    logic [7:0] data_out;
    logic       data_valid;
    logic       done;
    logic       busy;

    typedef struct {
        logic [7:0] d;
        logic       last;
    } beat_t;

    beat_t q[$];
    int    n_chk;
    int    n_err;
    bit    mon_en;

    rom_burst_reader #(
        .ADDR_W (4),
        .DATA_W (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cs         (cs),
        .rd         (rd),
        .addr       (addr),
        .len        (len),
        .data_out   (data_out),
        .data_valid (data_valid),
        .done       (done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] sq(input int i);
        int v;
        v = (i % 16) * (i % 16);
        return 8'(v % 256);
    endfunction

    task automatic push_burst(input int a, input int l);
        int le;
        le = (l > 16) ? 16 : l;
        for (int i = 0; i < le; i++) begin
            q.push_back('{d: sq(a + i), last: (i == le - 1)});
        end
    endtask

    // Start a burst at the next edge and count busy cycles afterwards.
    task automatic run_burst(input int a, input int l, output int nbusy);
        int le;
        le = (l > 16) ? 16 : l;
        push_burst(a, l);
        cs   = 1'b1;
        rd   = 1'b1;
        addr = 4'(a);
        len  = 5'(l);
        nbusy = 0;
        for (int i = 0; i < le + 2; i++) begin
            @(negedge clk);
            rd = 1'b0;
            if (busy === 1'b1) nbusy++;
        end
    endtask

    // Scoreboard monitor sampled on the falling edge.
    always @(negedge clk) begin
        beat_t e;
        if (mon_en && rst_n) begin
            if (data_valid === 1'b1) begin
                if (q.size() == 0) begin
                    chk("unexp_beat", {24'd0, data_out}, 32'hffff_ffff);
                end else begin
                    e = q.pop_front();
                    chk("beat_data", {24'd0, data_out}, {24'd0, e.d});
                    chk("beat_done", {31'd0, done}, {31'd0, e.last});
                end
            end else begin
                chk("idle_done", {31'd0, done}, 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        n_chk  = 0;
        n_err  = 0;
        mon_en = 1'b0;
        rst_n  = 1'b1;
        cs     = 1'b0;
        rd     = 1'b0;
        addr   = '0;
        len    = '0;

        // Asynchronous reset between edges.
        #3 rst_n = 1'b0;
        #1;
        chk("rst_data", {24'd0, data_out}, 32'd0);
        chk("rst_valid", {31'd0, data_valid}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_data", {24'd0, data_out}, 32'd0);
        chk("idle_valid", {31'd0, data_valid}, 32'd0);

        // Single read.
        run_burst(5, 1, nb);
        chk("single_busy", nb, 1);
        chk("single_valid_lo", {31'd0, data_valid}, 32'd0);
        chk("single_hold", {24'd0, data_out}, 32'h19);
        chk("single_sb", q.size(), 0);

        // Wrapping burst.
        run_burst(13, 5, nb);
        chk("wrap_busy", nb, 5);
        chk("wrap_sb", q.size(), 0);

        // Full depth.
        run_burst(0, 16, nb);
        chk("full_busy", nb, 16);
        chk("full_sb", q.size(), 0);

        // Oversized length clamps to full depth.
        run_burst(4, 31, nb);
        chk("clamp_busy", nb, 16);
        chk("clamp_sb", q.size(), 0);

        // Zero length is a no-op.
        run_burst(7, 0, nb);
        chk("zero_busy", nb, 0);
        chk("zero_hold", {24'd0, data_out}, {24'd0, sq(3)});

        // cs low with rd is ignored.
        cs   = 1'b0;
        rd   = 1'b1;
        addr = 4'd1;
        len  = 5'd3;
        repeat (3) begin
            @(negedge clk);
            chk("nocs_busy", {31'd0, busy}, 32'd0);
        end
        rd = 1'b0;
        cs = 1'b1;

        // Abort after two beats.
        push_burst(2, 2);
        q[1].last = 1'b0;
        rd   = 1'b1;
        addr = 4'd2;
        len  = 5'd6;
        @(negedge clk);
        rd = 1'b0;
        @(negedge clk);
        @(negedge clk);
        cs = 1'b0;
        @(negedge clk);
        chk("abort_valid", {31'd0, data_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_hold", {24'd0, data_out}, 32'h09);
        repeat (3) @(negedge clk);
        chk("abort_sb", q.size(), 0);
        cs = 1'b1;
        @(negedge clk);

        // rd during a burst does not restart it.
        push_burst(8, 4);
        rd   = 1'b1;
        addr = 4'd8;
        len  = 5'd4;
        @(negedge clk);
        rd = 1'b0;
        @(negedge clk);
        rd   = 1'b1;
        addr = 4'd0;
        len  = 5'd3;
        @(negedge clk);
        @(negedge clk);
        rd = 1'b0;
        repeat (4) @(negedge clk);
        chk("intf_sb", q.size(), 0);
        chk("intf_busy", {31'd0, busy}, 32'd0);

        // Reset mid-burst, then restart.
        push_burst(3, 2);
        q[1].last = 1'b0;
        rd   = 1'b1;
        addr = 4'd3;
        len  = 5'd8;
        @(negedge clk);
        rd = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_data", {24'd0, data_out}, 32'd0);
        chk("mrst_valid", {31'd0, data_valid}, 32'd0);
        chk("mrst_done", {31'd0, done}, 32'd0);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_sb", q.size(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_burst(1, 2, nb);
        chk("post_busy", nb, 2);
        chk("post_sb", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
